// File: rtl/key_entry_buffer_if.sv
// Keypad-side and buffer-side signals of the key entry buffer, grouped as one bundle.
interface key_entry_buffer_if #(
  parameter int CODE_W = 4,
  parameter int DEPTH  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                       press;
  logic [CODE_W-1:0]          scan_code;
  logic                       bksp;
  logic                       clr;
  logic [DEPTH-1:0]           buf_flag;
  logic [DEPTH*CODE_W-1:0]    key_buf_code;
  logic [CNT_W-1:0]           count;
  logic                       full;
  logic                       key_accept;
  logic                       key_reject;
  logic                       overflow;

  // Keypad scanner / host side: drives requests, observes the buffer.
  modport master (
    output press, scan_code, bksp, clr,
    input  buf_flag, key_buf_code, count, full, key_accept, key_reject, overflow
  );

  // Buffer side: samples requests, presents the buffered codes.
  modport slave (
    input  press, scan_code, bksp, clr,
    output buf_flag, key_buf_code, count, full, key_accept, key_reject, overflow
  );
endinterface

// File: rtl/key_entry_buffer.sv
// Key entry buffer: collects keypad scan codes newest-first in a packed shift
// buffer, with backspace, clear, and a selectable policy when the buffer is full.
module key_entry_buffer #(
  parameter int CODE_W    = 4,
  parameter int DEPTH     = 6,
  parameter bit FULL_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  key_entry_buffer_if.slave bus
);
  localparam int DATA_W = DEPTH * CODE_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              press_d, bksp_d, clr_d;
  logic              press_ev, bksp_ev, clr_ev;

  logic [DEPTH-1:0]  flag_q, flag_n;
  logic [DATA_W-1:0] code_q, code_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              full_q, full_n;
  logic              accept_q, accept_n;
  logic              reject_q, reject_n;
  logic              ovf_q, ovf_n;

  // Only the rising edge of each request level counts, so a held key acts once.
  assign press_ev = bus.press & ~press_d;
  assign bksp_ev  = bus.bksp  & ~bksp_d;
  assign clr_ev   = bus.clr   & ~clr_d;

  // Next buffer state: one operation per clock, clear beats backspace beats press.
  always_comb begin
    flag_n   = flag_q;
    code_n   = code_q;
    count_n  = count_q;
    accept_n = 1'b0;
    reject_n = 1'b0;
    ovf_n    = ovf_q;
    if (clr_ev) begin
      flag_n  = '0;
      code_n  = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end else if (bksp_ev) begin
      if (count_q != '0) begin
        code_n  = code_q >> CODE_W;
        flag_n  = flag_q >> 1;
        count_n = count_q - CNT_ONE;
      end
    end else if (press_ev) begin
      if (!full_q || !FULL_MODE) begin
        code_n   = (code_q << CODE_W) | DATA_W'(bus.scan_code);
        flag_n   = (flag_q << 1) | DEPTH'(1);
        accept_n = 1'b1;
        if (full_q) begin
          ovf_n = 1'b1;
        end else begin
          count_n = count_q + CNT_ONE;
        end
      end else begin
        reject_n = 1'b1;
        ovf_n    = 1'b1;
      end
    end
    full_n = (count_n == CNT_MAX);
  end

  // Edge registers and all outputs; reset wipes everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_d  <= 1'b0;
      bksp_d   <= 1'b0;
      clr_d    <= 1'b0;
      flag_q   <= '0;
      code_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      press_d  <= bus.press;
      bksp_d   <= bus.bksp;
      clr_d    <= bus.clr;
      flag_q   <= flag_n;
      code_q   <= code_n;
      count_q  <= count_n;
      full_q   <= full_n;
      accept_q <= accept_n;
      reject_q <= reject_n;
      ovf_q    <= ovf_n;
    end
  end

  assign bus.buf_flag     = flag_q;
  assign bus.key_buf_code = code_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.key_accept   = accept_q;
  assign bus.key_reject   = reject_q;
  assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: both full-buffer policies driven side by side,
// expected states queued by the stimulus and checked by a separate monitor.
module tb_key_entry_buffer;
  localparam int CW = 4;
  localparam int DP = 6;

  typedef logic [36:0] snap_t;
  typedef struct packed {
    snap_t e0;
    snap_t e1;
  } pair_t;

  logic clk;
  logic rst;

  key_entry_buffer_if #(.CODE_W(CW), .DEPTH(DP)) if0 ();
  key_entry_buffer_if #(.CODE_W(CW), .DEPTH(DP)) if1 ();

  key_entry_buffer #(.CODE_W(CW), .DEPTH(DP), .FULL_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  key_entry_buffer #(.CODE_W(CW), .DEPTH(DP), .FULL_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  int    acc0 = 0, acc1 = 0, rej0 = 0, rej1 = 0;
  pair_t sb[$];

  // Reference model: list of codes, index 0 newest, one list per policy.
  int mcode [2][DP];
  int mcnt  [2];
  bit mov   [2];
  bit macc  [2];
  bit mrej  [2];
  bit mp, mb, mc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t snap_of(input int m);
    snap_t s;
    if (m == 0) s = {if0.buf_flag, if0.key_buf_code, if0.count, if0.full,
                     if0.key_accept, if0.key_reject, if0.overflow};
    else        s = {if1.buf_flag, if1.key_buf_code, if1.count, if1.full,
                     if1.key_accept, if1.key_reject, if1.overflow};
    return s;
  endfunction

  function automatic snap_t model_snap(input int m);
    logic [23:0] c;
    logic [5:0]  f;
    c = '0;
    for (int i = 0; i < mcnt[m]; i++) c = c | (24'(mcode[m][i]) << (4 * i));
    f = 6'((1 << mcnt[m]) - 1);
    return {f, c, 3'(mcnt[m]), (mcnt[m] == DP), macc[m], mrej[m], mov[m]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < DP; i++) mcode[m][i] = 0;
      mcnt[m] = 0; mov[m] = 0; macc[m] = 0; mrej[m] = 0;
    end
    mp = 0; mb = 0; mc = 0;
  endtask

  task automatic model_step(input int m, input bit pe, input bit be, input bit ce, input int code);
    macc[m] = 0;
    mrej[m] = 0;
    if (ce) begin
      for (int i = 0; i < DP; i++) mcode[m][i] = 0;
      mcnt[m] = 0;
      mov[m]  = 0;
    end else if (be) begin
      if (mcnt[m] > 0) begin
        for (int i = 0; i < mcnt[m] - 1; i++) mcode[m][i] = mcode[m][i+1];
        mcode[m][mcnt[m]-1] = 0;
        mcnt[m]--;
      end
    end else if (pe) begin
      if (mcnt[m] == DP && m == 1) begin
        mrej[m] = 1;
        mov[m]  = 1;
      end else begin
        if (mcnt[m] == DP) mov[m] = 1;
        else mcnt[m]++;
        for (int i = DP - 1; i > 0; i--) mcode[m][i] = mcode[m][i-1];
        mcode[m][0] = code;
        macc[m] = 1;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Drives one clock of requests into both buffers and queues the expected result.
  task automatic apply_stimulus(input bit p, input bit b, input bit c, input logic [3:0] code);
    bit    pe, be, ce;
    pair_t e;
    if0.press = p; if0.bksp = b; if0.clr = c; if0.scan_code = code;
    if1.press = p; if1.bksp = b; if1.clr = c; if1.scan_code = code;
    pe = p & ~mp; be = b & ~mb; ce = c & ~mc;
    mp = p; mb = b; mc = c;
    model_step(0, pe, be, ce, int'(code));
    model_step(1, pe, be, ce, int'(code));
    e.e0 = model_snap(0);
    e.e1 = model_snap(1);
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUTs present a state, compare it against the queued one.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (if0.key_accept) acc0++;
        if (if1.key_accept) acc1++;
        if (if0.key_reject) rej0++;
        if (if1.key_reject) rej1++;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("sb_mode0", 64'(snap_of(0)), 64'(e.e0));
        check_output("sb_mode1", 64'(snap_of(1)), 64'(e.e1));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] rc;
    bit rp, rb, rcl;
    model_reset();
    rst = 1'b0;
    if0.press = 0; if0.bksp = 0; if0.clr = 0; if0.scan_code = '0;
    if1.press = 0; if1.bksp = 0; if1.clr = 0; if1.scan_code = '0;
    #12;
    check_output("reset_mode0", 64'(snap_of(0)), 64'd0);
    check_output("reset_mode1", 64'(snap_of(1)), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] fill past full, codes 1..7");
    acc0 = 0; acc1 = 0; rej0 = 0; rej1 = 0;
    for (int k = 1; k <= 7; k++) begin
      repeat (3) apply_stimulus(1, 0, 0, 4'(k));
      apply_stimulus(0, 0, 0, 4'h0);
    end
    @(negedge clk); #1;
    check_output("fill_code_mode0", 64'(if0.key_buf_code), 64'h234567);
    check_output("fill_count_mode0", 64'(if0.count), 64'd6);
    check_output("fill_full_mode0", 64'(if0.full), 64'd1);
    check_output("fill_ovf_mode0", 64'(if0.overflow), 64'd1);
    check_output("fill_acc_mode0", 64'(acc0), 64'd7);
    check_output("fill_code_mode1", 64'(if1.key_buf_code), 64'h123456);
    check_output("fill_ovf_mode1", 64'(if1.overflow), 64'd1);
    check_output("fill_acc_mode1", 64'(acc1), 64'd6);
    check_output("fill_rej_mode1", 64'(rej1), 64'd1);
    check_output("fill_rej_mode0", 64'(rej0), 64'd0);

    $display("[TB] clear");
    apply_stimulus(0, 0, 1, 4'h0);
    apply_stimulus(0, 0, 0, 4'h0);
    check_output("clr_ovf_mode0", 64'(if0.overflow), 64'd0);
    check_output("clr_count_mode1", 64'(if1.count), 64'd0);

    $display("[TB] backspace");
    apply_stimulus(1, 0, 0, 4'hA); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'hB); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'hC); apply_stimulus(0, 0, 0, 4'h0);
    repeat (2) begin
      apply_stimulus(0, 1, 0, 4'h0);
      apply_stimulus(0, 0, 0, 4'h0);
    end
    check_output("bksp_code", 64'(if0.key_buf_code), 64'h00000A);
    check_output("bksp_flag", 64'(if0.buf_flag), 64'b000001);
    check_output("bksp_count", 64'(if0.count), 64'd1);
    repeat (2) begin
      apply_stimulus(0, 1, 0, 4'h0);
      apply_stimulus(0, 0, 0, 4'h0);
    end
    check_output("bksp_empty_flag", 64'(if0.buf_flag), 64'd0);
    check_output("bksp_empty_count", 64'(if1.count), 64'd0);

    $display("[TB] coincident clr/bksp/press");
    apply_stimulus(1, 0, 0, 4'h1); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h2); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h3); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 1, 1, 4'h5);
    check_output("prio_count", 64'(if0.count), 64'd0);
    check_output("prio_code", 64'(if0.key_buf_code), 64'd0);
    check_output("prio_ovf", 64'(if0.overflow), 64'd0);
    check_output("prio_accept", 64'(if0.key_accept), 64'd0);
    apply_stimulus(0, 0, 0, 4'h0);

    $display("[TB] random stream");
    for (int n = 0; n < 300; n++) begin
      rp  = 1'($urandom_range(0, 1));
      rb  = ($urandom_range(0, 7) == 0);
      rcl = ($urandom_range(0, 15) == 0);
      rc  = 4'($urandom_range(0, 15));
      apply_stimulus(rp, rb, rcl, rc);
    end

    $display("[TB] asynchronous reset");
    apply_stimulus(0, 0, 1, 4'h0); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h9); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h8); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h7); apply_stimulus(0, 0, 0, 4'h0);
    apply_stimulus(1, 0, 0, 4'h6); apply_stimulus(0, 0, 0, 4'h0);
    check_output("pre_reset_code", 64'(if0.key_buf_code), 64'h009876);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_output("async_reset_mode0", 64'(snap_of(0)), 64'd0);
    check_output("async_reset_mode1", 64'(snap_of(1)), 64'd0);
    if0.press = 1; if0.scan_code = 4'hE;
    if1.press = 1; if1.scan_code = 4'hE;
    @(posedge clk); #1;
    check_output("held_reset_mode0", 64'(snap_of(0)), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    apply_stimulus(1, 0, 0, 4'hE);
    check_output("post_reset_count", 64'(if0.count), 64'd1);
    check_output("post_reset_code", 64'(if1.key_buf_code), 64'h00000E);
    check_output("post_reset_accept", 64'(if0.key_accept), 64'd1);
    apply_stimulus(1, 0, 0, 4'hE);
    apply_stimulus(0, 0, 0, 4'h0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 SHALL provide parameter CODE_W, default 4, meaning width of one key scan code.
REQ-002 SHALL provide parameter DEPTH, default 6, meaning number of code slots held (range 1..16).
REQ-003 SHALL provide parameter FULL_MODE, default 0, meaning full-buffer policy: 0 = shift out the oldest code, 1 = reject the new code.
REQ-004 SHALL have port clk  input  1  rising-edge system clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port press  input  1  key-pressed level from the keypad scanner, synchronous to clk.
REQ-007 SHALL have port scan_code  input  CODE_W  code of the pressed key, valid while press=1.
REQ-008 SHALL have port bksp  input  1  delete-newest-code request, synchronous level.
REQ-009 SHALL have port clr  input  1  clear-all request, synchronous level.
REQ-010 SHALL have port buf_flag  output  DEPTH  thermometer slot-valid flags; bit 0 = newest slot.
REQ-011 SHALL have port key_buf_code  output  DEPTH*CODE_W  packed codes; bits [CODE_W-1:0] = newest code.
REQ-012 SHALL have port count  output  clog2(DEPTH+1)  number of valid codes.
REQ-013 SHALL have port full  output  1  high when count==DEPTH.
REQ-014 SHALL have port key_accept  output  1  one-cycle pulse when a code is written.
REQ-015 SHALL have port key_reject  output  1  one-cycle pulse when a press is dropped (FULL_MODE=1, full).
REQ-016 SHALL have port overflow  output  1  sticky flag: a code was lost or rejected since the last clear.

Function
REQ-017 SHALL register press into press_d each clock; a press event SHALL be press=1 and press_d=0 (rising edge only); holding press SHALL produce exactly one event.
REQ-018 SHALL register bksp and clr with the same rising-edge detection; a level held high SHALL act once.
REQ-019 SHALL apply at most one operation per clock, with priority clr > bksp > press event.
REQ-020 SHALL treat a lower-priority event that coincides with a higher-priority one as lost, with no deferral and no key_reject.
REQ-021 On clr event SHALL set buf_flag=0, key_buf_code=0, count=0, and overflow=0.
REQ-022 On press event with count<DEPTH SHALL shift key_buf_code left by CODE_W and insert scan_code at bits [CODE_W-1:0].
REQ-023 On the same event SHALL shift buf_flag left inserting 1, increment count, and pulse key_accept.
REQ-024 On press event with full and FULL_MODE=0 SHALL perform the same shift, discarding the oldest code.
REQ-025 In that case SHALL leave count=DEPTH, pulse key_accept, and set overflow.
REQ-026 On press event with full and FULL_MODE=1 SHALL leave the buffer unchanged, pulse key_reject, and set overflow.
REQ-027 On bksp event with count>0 SHALL shift key_buf_code right by CODE_W, zero-filling the oldest slot.
REQ-028 On the same event SHALL shift buf_flag right inserting 0 at the top and decrement count.
REQ-029 On bksp event with count==0 SHALL change nothing and pulse nothing.
REQ-030 All outputs SHALL be registered and SHALL reflect an event at the same rising edge that samples it (latency 1 clock from input edge to output).
REQ-031 Invalid slots SHALL always hold code 0.
REQ-032 buf_flag SHALL always equal (1<<count)-1.
REQ-033 key_accept and key_reject SHALL never be high together.

Reset
REQ-034 While rst=0, all outputs, press_d, and the bksp/clr edge registers SHALL be 0, asynchronously and independent of clk.
REQ-035 Reset asserted mid-operation SHALL discard all contents.
REQ-036 After rst rises, a press already held high SHALL be accepted at the first clock edge as a rising edge (press_d=0).

Verification
REQ-037 DEPTH=6, CODE_W=4, FULL_MODE=0: rising edges of press with codes 1..7, each held 3 clocks, SHALL give key_buf_code=0x234567, count=6, full=1, overflow=1, and 7 key_accept pulses.
REQ-038 Same stimulus with FULL_MODE=1 SHALL give key_buf_code=0x123456, one key_reject pulse on the 7th press, and overflow=1.
REQ-039 Codes A,B,C followed by two bksp edges SHALL give key_buf_code=0x00000A, buf_flag=000001, and count=1; a third and fourth bksp SHALL give an empty buffer with no pulses.
REQ-040 clr, bksp, and a press edge in the same clock with the buffer holding 3 codes SHALL give an empty buffer, overflow=0, and no key_accept.
REQ-041 rst driven low between clock edges with 4 codes stored SHALL clear all outputs immediately; rst high with press held SHALL accept one code at the next edge.
REQ-042 Random press/bksp/clr stream against a reference queue model SHALL show buf_flag==(1<<count)-1 and matching contents every cycle.
